// File: rtl/jtvigil_obj_draw.sv
// Sprite row drawer: fetches two 32-bit 4bpp words per 16-pixel row and
// streams the opaque pixels into the object line buffer, one per cycle.
module jtvigil_obj_draw (
  input  logic        clk,
  input  logic        rst,
  input  logic        draw_start,
  input  logic [12:0] code,
  input  logic [3:0]  vrow,
  input  logic        hflip,
  input  logic [3:0]  pal,
  input  logic [8:0]  xpos,
  output logic        busy,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_din
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAW} state_t;

  state_t      st, st_nx;
  logic [12:0] code_l, code_nx;
  logic [3:0]  vrow_l, vrow_nx;
  logic        hflip_l, hflip_nx;
  logic [3:0]  pal_l, pal_nx;
  logic [8:0]  xpos_l, xpos_nx;
  logic        half, half_nx;
  logic [2:0]  pcnt, pcnt_nx;
  logic [31:0] word, word_nx;

  logic        busy_nx, cs_nx, we_nx;
  logic [17:0] addr_nx;
  logic [8:0]  baddr_nx;
  logic [7:0]  din_nx;
  logic [2:0]  m;
  logic [31:0] sh;
  logic [3:0]  pix;

  always_comb begin
    st_nx    = st;
    code_nx  = code_l;
    vrow_nx  = vrow_l;
    hflip_nx = hflip_l;
    pal_nx   = pal_l;
    xpos_nx  = xpos_l;
    half_nx  = half;
    pcnt_nx  = pcnt;
    word_nx  = word;
    case (st)
      IDLE: if (draw_start) begin
        code_nx  = code;
        vrow_nx  = vrow;
        hflip_nx = hflip;
        pal_nx   = pal;
        xpos_nx  = xpos;
        half_nx  = hflip;
        pcnt_nx  = 3'd0;
        st_nx    = REQ;
      end
      // rom_ok may still reflect the previous address here
      REQ:  st_nx = WAIT;
      WAIT: if (rom_ok) begin
        word_nx = rom_data;
        pcnt_nx = 3'd0;
        st_nx   = DRAW;
      end
      DRAW: if (pcnt == 3'd7) begin
        if (half == hflip_l) begin
          half_nx = ~half;
          pcnt_nx = 3'd0;
          st_nx   = REQ;
        end else begin
          st_nx = IDLE;
        end
      end else begin
        pcnt_nx = pcnt + 3'd1;
      end
      default: st_nx = IDLE;
    endcase

    // Outputs are computed from the upcoming state so they can be registered.
    busy_nx  = (st_nx != IDLE);
    cs_nx    = (st_nx == REQ) || (st_nx == WAIT);
    addr_nx  = cs_nx ? {code_nx, half_nx, vrow_nx} : rom_addr;
    m        = hflip_nx ? pcnt_nx : 3'd7 - pcnt_nx;
    sh       = word_nx >> m;
    pix      = {sh[24], sh[16], sh[8], sh[0]};
    we_nx    = (st_nx == DRAW) && (pix != 4'hF);
    baddr_nx = buf_addr;
    din_nx   = buf_din;
    if (st_nx == DRAW) begin
      baddr_nx = xpos_nx + {5'd0, half_nx ^ hflip_nx, pcnt_nx};
      din_nx   = {pal_nx, pix};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      code_l   <= '0;
      vrow_l   <= '0;
      hflip_l  <= 1'b0;
      pal_l    <= '0;
      xpos_l   <= '0;
      half     <= 1'b0;
      pcnt     <= '0;
      word     <= '0;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_din  <= '0;
    end else begin
      st       <= st_nx;
      code_l   <= code_nx;
      vrow_l   <= vrow_nx;
      hflip_l  <= hflip_nx;
      pal_l    <= pal_nx;
      xpos_l   <= xpos_nx;
      half     <= half_nx;
      pcnt     <= pcnt_nx;
      word     <= word_nx;
      busy     <= busy_nx;
      rom_cs   <= cs_nx;
      rom_addr <= addr_nx;
      buf_we   <= we_nx;
      buf_addr <= baddr_nx;
      buf_din  <= din_nx;
    end
  end

endmodule

// File: tb/tb_jtvigil_obj_draw.sv
// Bench for jtvigil_obj_draw: ROM responder with programmable latency and a
// per-row reference of ROM addresses and opaque line-buffer writes.
module tb_jtvigil_obj_draw;

  logic        clk = 1'b0;
  logic        rst, draw_start, hflip, busy, rom_cs, rom_ok, buf_we;
  logic [12:0] code;
  logic [3:0]  vrow, pal;
  logic [8:0]  xpos, buf_addr;
  logic [17:0] rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  buf_din;

  int          passed = 0, total = 0;
  int          rom_lat = 0;
  bit          rom_fixed = 1'b0;
  logic [31:0] fixed_word = 32'h0, rom_seed = 32'h1234_5678;

  jtvigil_obj_draw dut (
    .clk(clk), .rst(rst), .draw_start(draw_start), .code(code), .vrow(vrow),
    .hflip(hflip), .pal(pal), .xpos(xpos), .busy(busy), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [17:0] a);
    if (rom_fixed) return fixed_word;
    return (32'(a) * 32'h9E37_79B1) ^ rom_seed;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ROM: stale data/ok in the request cycle, valid data rom_lat cycles later.
  initial begin
    logic        rcs;
    logic [17:0] raddr;
    int          rcnt;
    rcs = 1'b0; raddr = '0; rcnt = 0;
    rom_ok = 1'b1; rom_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rom_cs && (!rcs || rom_addr != raddr)) begin
        raddr = rom_addr; rcnt = 0; rom_ok = 1'b1;
        rom_data = (rom_lat == 0) ? romw(rom_addr) : ~romw(rom_addr);
      end else if (rom_cs) begin
        rcnt++;
        if (rom_lat > 0) rom_ok = (rcnt >= rom_lat);
        if (rom_ok) rom_data = romw(raddr);
      end
      rcs = rom_cs;
    end
  end

  // Called just after a negedge; returns at the negedge where busy has fallen.
  task automatic run_sprite(input logic [12:0] c, input logic [3:0] vr, input logic h,
                            input logic [3:0] p, input logic [8:0] x, input int lat,
                            input bit poke);
    logic [17:0] ea [2];
    logic [16:0] ew [$];
    logic [16:0] ow [$];
    logic [17:0] oa [$];
    logic [31:0] w;
    logic [3:0]  px;
    logic [8:0]  ad;
    logic        pcs;
    logic [17:0] paddr;
    int          m, bcyc;
    bit          seen, done;
    rom_lat = lat;
    ea[0] = {c, h, vr};
    ea[1] = {c, ~h, vr};
    // 16 pixels land left to right; each word is read MSB-first unless mirrored.
    for (int i = 0; i < 16; i++) begin
      w  = romw(ea[i / 8]);
      m  = h ? (i % 8) : 7 - (i % 8);
      px = {w[24 + m], w[16 + m], w[8 + m], w[m]};
      ad = x + 9'(i);
      if (px != 4'hF) ew.push_back({ad, p, px});
    end
    code = c; vrow = vr; hflip = h; pal = p; xpos = x; draw_start = 1'b1;
    pcs = rom_cs; paddr = rom_addr; bcyc = 0; seen = 0; done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) draw_start = 1'b0;
      if (poke && cyc == 6) begin
        draw_start = 1'b1; code = ~c; pal = ~p; hflip = ~h; xpos = x + 9'd100;
      end
      if (poke && cyc == 7) draw_start = 1'b0;
      if (busy) begin bcyc++; seen = 1; end
      else if (seen) done = 1;
      if (rom_cs && (!pcs || rom_addr != paddr)) oa.push_back(rom_addr);
      pcs = rom_cs; paddr = rom_addr;
      if (buf_we) ow.push_back({buf_addr, buf_din});
    end
    chk("row_done", 64'(done), 64'd1);
    chk("busy_cycles", 64'(bcyc), 64'(2 * (9 + (lat < 1 ? 1 : lat))));
    chk("rom_req_cnt", 64'(oa.size()), 64'd2);
    for (int i = 0; i < 2 && i < oa.size(); i++) chk("rom_addr", 64'(oa[i]), 64'(ea[i]));
    chk("wr_cnt", 64'(ow.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < ow.size(); i++) chk("wr_addr_din", 64'(ow[i]), 64'(ew[i]));
  endtask

  task automatic reset_mid();
    int k;
    bit hit;
    rom_fixed = 1; fixed_word = 32'h00FF_00FF; rom_lat = 0;
    code = 13'h0AAA; vrow = 4'd3; hflip = 1'b0; pal = 4'h6; xpos = 9'h040;
    draw_start = 1'b1; k = 0; hit = 0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      draw_start = 1'b0;
      if (buf_we) begin
        if (k == 3) hit = 1;
        k++;
      end
    end
    chk("rst_reach_px3", 64'(hit), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 64'({busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_after", 64'({busy, buf_we, rom_cs}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; draw_start = 1'b1; code = 13'h1FFF; vrow = 4'hF; hflip = 1'b1;
    pal = 4'hF; xpos = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", 64'({busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din}), 64'd0);
    end
    rst = 1'b0; draw_start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, rom_cs, buf_we}), 64'd0);

    rom_fixed = 1; fixed_word = 32'h0F0F_00FF;
    run_sprite(13'h0123, 4'd5, 1'b0, 4'hA, 9'h010, 0, 0);
    run_sprite(13'h0123, 4'd5, 1'b1, 4'hA, 9'h010, 0, 0);
    fixed_word = 32'hF0F0_F0F0;
    run_sprite(13'h0777, 4'd9, 1'b0, 4'h3, 9'h080, 0, 0);
    fixed_word = 32'h00FF_00FF;
    run_sprite(13'h1ABC, 4'd2, 1'b0, 4'h5, 9'h1FC, 0, 0);
    run_sprite(13'h1ABC, 4'd2, 1'b1, 4'h5, 9'h1FC, 0, 0);

    rom_fixed = 0;
    run_sprite(13'h0123, 4'd5, 1'b0, 4'hA, 9'h010, 5, 1);
    for (int i = 0; i < 6; i++) begin
      rom_seed = $urandom;
      run_sprite(13'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                 9'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    reset_mid();
    rom_fixed = 0; rom_seed = $urandom;
    run_sprite(13'h0555, 4'd7, 1'b1, 4'hC, 9'h100, 2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
